timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Control stage that sits around the team's free-running `counter` block.
- Upstream side: drives the counter's `enable` and a clear pulse to its asynchronous reset input.
- Downstream side: consumes the counter's `max_hit` and `count`.
- Function: turns the counter into a programmable one-shot/periodic timer with a prescaler, a period countdown, interrupt and done pulses, and a count snapshot on abort.

Parameters:
- MAX_COUNT, 256: must equal the attached counter's MAX_COUNT; one counter period = MAX_COUNT+1 enables.
- PRESCALE, 4: clock cycles per counter enable; legal range >= 1.
- PERIOD_W, 8: width of the period-count field.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: start request; sampled only in IDLE.
- stop, in, 1: abort request.
- pause, in, 1: level; freezes the prescaler while high.
- periodic, in, 1: 1 = periodic, 0 = one-shot; latched at start.
- num_periods, in, PERIOD_W: number of periods; latched at start; 0 in periodic mode = run forever.
- cnt_max_hit, in, 1: from counter `max_hit`.
- cnt_count, in, $clog2(MAX_COUNT)+1: from counter `count`.
- cnt_enable, out, 1: to counter `enable`.
- cnt_clr, out, 1: registered one-cycle clear; integrator ORs it with ~rst_n onto the counter's active-high `rst`.
- busy, out, 1: high in CLEAR or RUN.
- irq, out, 1: one-cycle pulse per completed period.
- done, out, 1: one-cycle pulse on normal completion.
- periods_left, out, PERIOD_W: remaining periods.
- snapshot, out, $clog2(MAX_COUNT)+1: cnt_count captured on stop.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, prescaler 0, and all outputs 0 (cnt_enable, cnt_clr, busy, irq, done, periods_left, snapshot).
- States: IDLE, CLEAR, RUN.
- IDLE:
  - start=1 and stop=0 at an edge: go to CLEAR and set cnt_clr=1 (flop).
  - Latch periodic.
  - Load periods_left: num_periods in periodic mode; forced to 1 in one-shot mode.
  - start with stop high in the same cycle: stay IDLE (stop wins).
- CLEAR: exactly one cycle, cnt_clr=1, cnt_enable=0.
  - Next edge: RUN, prescaler=0, cnt_clr=0.
  - stop during CLEAR: go to IDLE, snapshot <= 0.
- RUN prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - Holds its value while pause=1.
  - tick = (presc==PRESCALE-1) && !pause.
  - cnt_enable = (state==RUN) && tick, decoded from registers only.
  - PRESCALE=1: tick every unpaused RUN cycle.
- Period end event: cnt_enable && cnt_max_hit (the counter wraps to 0 on that edge).
  - irq=1 for the following cycle.
  - Infinite mode (periodic with periods_left==0): stay in RUN, periods_left unchanged.
  - Otherwise, periods_left decrements. If it was 1: go to IDLE, done=1 and busy=0 in the following cycle.
  - Periodic mode: the counter is not cleared between periods; the prescaler keeps free-running.
- stop in RUN: go to IDLE next edge, snapshot <= cnt_count, done stays 0.
  - stop coincident with a period end: irq still pulses and periods_left still decrements, but done stays 0.
- start while busy: ignored, no restart.
- Latency: with a start edge at 0, N periods finish with done high in the cycle after edge 1 + N·PRESCALE·(MAX_COUNT+1), assuming no pause.
- pause held across cycles stretches the timing 1:1 and never drops a tick.
- Reset mid-run: immediate IDLE; cnt_clr is not asserted, since the counter shares the system reset.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE, CLEAR, RUN);
  - localparam function for the count width ($clog2(MAX_COUNT)+1), shared with counter users.
- Sub-module tick_prescaler:
  - Inputs: clk, rst_n, clr, hold.
  - Output: tick.
  - Parameter: PRESCALE.
- FSM, period countdown and snapshot stay in timer_ctrl.

Test Plan:
All cases use MAX_COUNT=3, PRESCALE=2, PERIOD_W=4 with a real counter instance attached.
- One-shot: periodic=0, start at edge 0.
  - cnt_clr high in cycle 0.
  - cnt_enable sampled at edges 3, 5, 7, 9.
  - irq=done=1 in cycle 9; busy=0 from cycle 9; count=0.
- Periodic: num_periods=3.
  - irq at cycles 9, 17, 25; done only at cycle 25.
  - periods_left reads 2, 1, 0 after each irq.
- Infinite: periodic=1, num_periods=0, run 100 cycles.
  - irq every 8 cycles; busy stays 1.
  - stop at cycle 50: IDLE at cycle 51, snapshot = count at edge 50, no done.
- Pause: hold pause for 5 cycles mid-period of a one-shot.
  - done is delayed by exactly 5 cycles (cycle 14).
  - No enable is issued while paused.
- Collisions:
  - stop on the same edge as the final period end: irq=1, done=0, periods_left=0.
  - start+stop in IDLE: remains IDLE.
  - start while busy: no change.
- Reset: drop rst_n in the middle of RUN.
  - All outputs 0 asynchronously.
  - After release, a fresh start behaves as in the one-shot case.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state type and counter width helper for timer_ctrl
package timer_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  function automatic int count_w(int max_count);
    return $clog2(max_count) + 1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to one tick every PRESCALE unheld cycles
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] presc;
  assign tick = presc == W'(PRESCALE - 1) && !hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc <= '0;
    else if (clr) presc <= '0;
    else if (!hold) presc <= tick ? '0 : presc + 1'b1;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: one-shot/periodic timer control wrapped around a free-running counter
module timer_ctrl import timer_pkg::*; #(
  parameter int MAX_COUNT = 256,
  parameter int PRESCALE  = 4,
  parameter int PERIOD_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            pause,
  input  logic                            periodic,
  input  logic [PERIOD_W-1:0]             num_periods,
  input  logic                            cnt_max_hit,
  input  logic [count_w(MAX_COUNT)-1:0]   cnt_count,
  output logic                            cnt_enable,
  output logic                            cnt_clr,
  output logic                            busy,
  output logic                            irq,
  output logic                            done,
  output logic [PERIOD_W-1:0]             periods_left,
  output logic [count_w(MAX_COUNT)-1:0]   snapshot
);
  localparam int CW = count_w(MAX_COUNT);
  state_t state, state_n;
  logic per, per_n, tick, pend, clr_n, irq_n, done_n;
  logic [PERIOD_W-1:0] left_n;
  logic [CW-1:0] snap_n;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != RUN),
    .hold (pause),
    .tick (tick)
  );
  assign cnt_enable = state == RUN && tick;
  assign pend = cnt_enable && cnt_max_hit;
  assign busy = state != IDLE;
  // Periodic with zero periods runs until stopped, so the countdown is frozen.
  always_comb begin
    state_n = state;
    per_n = per;
    left_n = periods_left;
    snap_n = snapshot;
    clr_n = 1'b0;
    irq_n = pend;
    done_n = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_n = CLEAR;
        clr_n = 1'b1;
        per_n = periodic;
        left_n = periodic ? num_periods : PERIOD_W'(1);
      end
      CLEAR: begin
        state_n = stop ? IDLE : RUN;
        snap_n = stop ? '0 : snapshot;
      end
      RUN: begin
        if (pend && !(per && periods_left == '0)) begin
          left_n = periods_left - 1'b1;
          if (periods_left == PERIOD_W'(1) && !stop) begin
            state_n = IDLE;
            done_n = 1'b1;
          end
        end
        if (stop) begin
          state_n = IDLE;
          snap_n = cnt_count;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      per <= 1'b0;
      periods_left <= '0;
      snapshot <= '0;
      cnt_clr <= 1'b0;
      irq <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      per <= per_n;
      periods_left <= left_n;
      snapshot <= snap_n;
      cnt_clr <= clr_n;
      irq <= irq_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: random and directed checks of timer_ctrl against an arithmetic timer model
module tb_timer_ctrl;
  import timer_pkg::*;
  localparam int M = 3, P = 2, PW = 4, CW = count_w(M);
  logic clk = 0, rst_n = 0, start = 0, stop = 0, pause = 0, periodic = 0;
  logic [PW-1:0] num_periods = '0;
  logic cnt_max_hit, cnt_enable, cnt_clr, busy, irq, done;
  logic [CW-1:0] cnt_count, snapshot;
  logic [PW-1:0] periods_left;
  logic crst;
  int total = 0, bad = 0;
  int phase, ticks, ens, m_left, m_snap;
  bit m_per, m_irq, m_done, m_clr;

  always #5 clk = ~clk;

  // Behavioural stand-in for the team's counter block.
  assign crst = ~rst_n | cnt_clr;
  assign cnt_max_hit = cnt_count == CW'(M);
  always_ff @(posedge clk or posedge crst)
    if (crst) cnt_count <= '0;
    else if (cnt_enable) cnt_count <= cnt_count == CW'(M) ? '0 : cnt_count + 1'b1;

  timer_ctrl #(.MAX_COUNT(M), .PRESCALE(P), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .num_periods(num_periods), .cnt_max_hit(cnt_max_hit),
    .cnt_count(cnt_count), .cnt_enable(cnt_enable), .cnt_clr(cnt_clr),
    .busy(busy), .irq(irq), .done(done), .periods_left(periods_left),
    .snapshot(snapshot)
  );

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; ticks = 0; ens = 0; m_left = 0; m_snap = 0;
    m_per = 0; m_irq = 0; m_done = 0; m_clr = 0;
  endtask

  // Model: phase 0/1/2 = idle/clear/run; enables fall on every P-th unpaused
  // run cycle and a period ends on every (M+1)-th enable.
  task automatic step();
    bit en_m, pe;
    int cv;
    @(negedge clk);
    en_m = phase == 2 && !pause && (ticks % P == P - 1);
    chk("cnt_enable", int'(cnt_enable), int'(en_m));
    @(posedge clk);
    m_irq = 0; m_done = 0; m_clr = 0;
    if (phase == 0) begin
      if (start && !stop) begin
        phase = 1; m_clr = 1; m_per = periodic;
        m_left = periodic ? int'(num_periods) : 1;
      end
    end else if (phase == 1) begin
      if (stop) begin phase = 0; m_snap = 0; end
      else begin phase = 2; ticks = 0; ens = 0; end
    end else begin
      cv = ens % (M + 1);
      pe = en_m && cv == M;
      if (en_m) ens++;
      if (!pause) ticks++;
      if (pe) begin
        m_irq = 1;
        if (!(m_per && m_left == 0)) begin
          m_left--;
          if (m_left == 0 && !stop) begin phase = 0; m_done = 1; end
        end
      end
      if (stop) begin phase = 0; m_snap = cv; end
    end
    #1;
    chk("busy", int'(busy), int'(phase != 0));
    chk("irq", int'(irq), int'(m_irq));
    chk("done", int'(done), int'(m_done));
    chk("cnt_clr", int'(cnt_clr), int'(m_clr));
    chk("periods_left", int'(periods_left), m_left);
    chk("snapshot", int'(snapshot), m_snap);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_en"}, int'(cnt_enable), 0);
    chk({tag, "_clr"}, int'(cnt_clr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_irq"}, int'(irq), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_left"}, int'(periods_left), 0);
    chk({tag, "_snap"}, int'(snapshot), 0);
  endtask

  // Start at the next edge (cycle 0) and return the cycle where done appears.
  task automatic launch(input bit per, input int n, input int pause_at, input int pause_len,
                        output int done_cyc);
    periodic = per; num_periods = PW'(n); start = 1;
    step();
    start = 0;
    done_cyc = -1;
    for (int c = 1; c < 80 && done_cyc < 0; c++) begin
      pause = c > pause_at && c <= pause_at + pause_len;
      step();
      if (done) done_cyc = c;
    end
    pause = 0;
  endtask

  initial begin
    int dc, nirq;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    #3 rst_n = 1;

    launch(0, 0, 0, 0, dc);
    chk("oneshot_done_cycle", dc, 9);
    chk("oneshot_count", int'(cnt_count), 0);

    launch(1, 3, 0, 0, dc);
    chk("periodic3_done_cycle", dc, 25);

    launch(0, 0, 3, 5, dc);
    chk("pause_done_cycle", dc, 14);

    // Infinite periodic, stopped at cycle 50.
    periodic = 1; num_periods = '0; start = 1;
    step();
    start = 0; nirq = 0;
    for (int c = 1; c <= 50; c++) begin
      step();
      nirq += int'(irq);
    end
    chk("inf_irq_count", nirq, 6);
    chk("inf_busy", int'(busy), 1);
    stop = 1;
    step();
    stop = 0;
    chk("inf_stop_busy", int'(busy), 0);
    repeat (3) step();

    // Stop coinciding with the final period end of a one-shot.
    periodic = 0; start = 1;
    step();
    start = 0;
    repeat (8) step();
    stop = 1;
    step();
    stop = 0;
    chk("collide_irq", int'(irq), 1);
    chk("collide_done", int'(done), 0);
    chk("collide_left", int'(periods_left), 0);

    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    chk("start_stop_idle", int'(busy), 0);

    // Start while busy must not restart the run.
    periodic = 0; start = 1;
    step();
    repeat (4) step();
    periodic = 1; num_periods = 4'd5;
    repeat (3) step();
    start = 0;
    for (int c = 0; c < 20 && busy; c++) step();
    chk("busy_restart_ignored", int'(busy), 0);

    // Asynchronous reset in the middle of RUN.
    periodic = 1; num_periods = 4'd2; start = 1;
    step();
    start = 0;
    repeat (6) step();
    #1 rst_n = 0;
    #1 check_all_zero("async_rst");
    #1 rst_n = 1;
    model_reset();
    launch(0, 0, 0, 0, dc);
    chk("post_rst_done_cycle", dc, 9);

    for (int i = 0; i < 800; i++) begin
      start = $urandom_range(0, 5) == 0;
      stop = $urandom_range(0, 29) == 0;
      pause = $urandom_range(0, 3) == 0;
      periodic = 1'($urandom_range(0, 1));
      num_periods = PW'($urandom_range(0, 3));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
